lcd16x2_arbiter: RTL

Shares one lcd16x2 character-LCD driver among NUM_REQ independent requesters, such as a text printer, a cursor/command sequencer and a status-field updater. Each accepted request becomes exactly one enb/rdy transaction on the driver. Requesters are served round-robin, and a watchdog recovers if the driver never acknowledges. The block sits between the application-level sequencers and the lcd16x2 instance, and drives the driver's data_i, ops_i and enb_i.

---
 rtl/lcd16x2_pkg.sv | 21 ++
 rtl/lcd_rr_pick.sv | 29 ++
 rtl/lcd16x2_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lcd16x2_pkg.sv
// rtl/lcd16x2_pkg.sv - shared types, opcodes and width helper for the lcd16x2 arbiter
package lcd16x2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic [1:0] LCD_OPS_CMD  = 2'd0;
    localparam logic [1:0] LCD_OPS_DATA = 2'd1;

    // Never returns less than 1 so a width derived from it is always legal.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// rtl/lcd_rr_pick.sv - combinational round-robin picker scanning upward from ptr+1 with wrap
module lcd_rr_pick
    import lcd16x2_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int PW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = ptr;
        for (int s = 0; s < NUM_REQ; s++) begin
            idx = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd16x2_arbiter.sv
// rtl/lcd16x2_arbiter.sv - round-robin sharing of one lcd16x2 driver; LCD_ARB_LOCK_EN adds lock_i
module lcd16x2_arbiter
    import lcd16x2_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*8-1:0] data_i,
    input  logic [NUM_REQ*2-1:0] ops_i,
`ifdef LCD_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   lock_i,
`endif
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic [7:0]           lcd_data_o,
    output logic [1:0]           lcd_ops_o,
    output logic                 lcd_enb_o,
    input  logic                 lcd_rdy_i
);

    localparam int PW = clog2(NUM_REQ);
    localparam int CW = clog2(TIMEOUT_CYC);

    arb_state_t         state, state_n;
    logic [PW-1:0]      ptr, ptr_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               lock_hold, lock_hold_n;

    logic [NUM_REQ-1:0] pick_gnt, win;
    logic               pick_valid, win_valid;
    logic [PW-1:0]      win_idx;
    logic [7:0]         win_data;
    logic [1:0]         win_ops;

    logic [NUM_REQ-1:0] gnt_n, done_n;
    logic               err_n, busy_n, enb_n;
    logic [7:0]         data_n;
    logic [1:0]         ops_n;

    lcd_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // A held lock regrants the previous owner ahead of the round-robin scan.
    always_comb begin
        win       = pick_gnt;
        win_valid = pick_valid;
`ifdef LCD_ARB_LOCK_EN
        if (lock_hold && req_i[ptr]) begin
            win      = '0;
            win[ptr] = 1'b1;
            win_valid = 1'b1;
        end
`endif
        win_idx  = '0;
        win_data = '0;
        win_ops  = LCD_OPS_CMD;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win[k]) begin
                win_idx  = PW'(k);
                win_data = data_i[8*k +: 8];
                win_ops  = ops_i[2*k +: 2];
            end
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cnt_n       = cnt;
        lock_hold_n = lock_hold;
        gnt_n       = '0;
        done_n      = '0;
        err_n       = 1'b0;
        enb_n       = lcd_enb_o;
        data_n      = lcd_data_o;
        ops_n       = lcd_ops_o;
        case (state)
            IDLE: begin
                if (lock_hold && !req_i[ptr]) lock_hold_n = 1'b0;
                if (lcd_rdy_i && win_valid) begin
                    state_n = ISSUE;
                    gnt_n   = win;
                    ptr_n   = win_idx;
                    cnt_n   = '0;
                    enb_n   = 1'b1;
                    data_n  = win_data;
                    ops_n   = win_ops;
                end
            end
            ISSUE: begin
                if (!lcd_rdy_i) begin
                    state_n = WAIT;
                    enb_n   = 1'b0;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state_n     = IDLE;
                    enb_n       = 1'b0;
                    err_n       = 1'b1;
                    lock_hold_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT: begin
                if (lcd_rdy_i) begin
                    state_n     = IDLE;
                    done_n[ptr] = 1'b1;
`ifdef LCD_ARB_LOCK_EN
                    lock_hold_n = lock_i[ptr];
`else
                    lock_hold_n = 1'b0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        // Busy spans the grant cycle through the completion (or abort) pulse.
        busy_n = (state_n != IDLE) || (|done_n) || err_n;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            ptr        <= PW'(NUM_REQ - 1);
            cnt        <= '0;
            lock_hold  <= 1'b0;
            gnt_o      <= '0;
            done_o     <= '0;
            err_o      <= 1'b0;
            busy_o     <= 1'b0;
            lcd_enb_o  <= 1'b0;
            lcd_data_o <= '0;
            lcd_ops_o  <= LCD_OPS_CMD;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            cnt        <= cnt_n;
            lock_hold  <= lock_hold_n;
            gnt_o      <= gnt_n;
            done_o     <= done_n;
            err_o      <= err_n;
            busy_o     <= busy_n;
            lcd_enb_o  <= enb_n;
            lcd_data_o <= data_n;
            lcd_ops_o  <= ops_n;
        end
    end

endmodule
